// File: rtl/udp_rx_frame_filter.sv
// udp_rx_frame_filter: buffers each UDP RX payload, checks the magic byte, the
// length range and (optionally) a trailing XOR checksum, then replays the good
// payload bytes on a contiguous valid/data/length stream. Bad frames are dropped
// and counted.
// Build option: define UDP_FILTER_CHECKSUM_EN to make the last payload byte an
// XOR checksum that is verified and stripped. Without it every byte after the
// header is forwarded and no checksum is checked.
module udp_rx_frame_filter #(
   parameter logic [7:0] MAGIC     = 8'hA5,
   parameter int         BUF_DEPTH = 64,
   parameter int         MIN_LEN   = 3
) (
   input  logic        udp_rx_clk,
   input  logic        reset,
   input  logic        app_rx_data_valid,
   input  logic [7:0]  app_rx_data,
   input  logic [15:0] app_rx_data_length,
   output logic        out_data_valid,
   output logic [7:0]  out_data,
   output logic [15:0] out_data_length,
   output logic [15:0] frame_ok_cnt,
   output logic [15:0] frame_drop_cnt
);

   localparam int AW = $clog2(BUF_DEPTH);

`ifdef UDP_FILTER_CHECKSUM_EN
   // Header and trailing checksum are stripped.
   localparam logic [15:0] TRIM    = 16'd2;
   localparam logic [15:0] MIN_EFF = 16'(MIN_LEN);
`else
   // Only the header is stripped; one byte less is needed for a valid frame.
   localparam logic [15:0] TRIM    = 16'd1;
   localparam logic [15:0] MIN_EFF = 16'(MIN_LEN - 1);
`endif
   localparam logic [15:0] MAX_LEN = 16'(BUF_DEPTH);

   typedef enum logic [1:0] {IDLE, RECV, CHECK, SEND} state_t;

   state_t      state_q, state_d;
   logic [15:0] pos_q, pos_d;           // byte position inside the current input frame
   logic [15:0] len_q, len_d;           // length latched at the frame start byte
   logic        drop_pend_q, drop_pend_d; // current input frame was rejected at start
   logic [7:0]  csum_q, csum_d;
   logic        csum_ok_q, csum_ok_d;
   logic [15:0] snd_len_q, snd_len_d;   // number of bytes to replay
   logic [15:0] rd_addr_q, rd_addr_d;
   logic        out_vld_q, out_vld_d;
   logic [7:0]  out_data_q, out_data_d;
   logic [15:0] out_len_q, out_len_d;
   logic [15:0] ok_cnt_q, ok_cnt_d;
   logic [15:0] drop_cnt_q, drop_cnt_d;

   logic [7:0]  mem_q [BUF_DEPTH];
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data;

   logic [15:0] cur_len;
   logic        in_start, in_end, len_ok, accept;
   logic        drop_trk, drop_chk;

   // Input tracker decode: frame start/end and the accept decision.
   always_comb begin
      cur_len  = (pos_q == 16'd0) ? app_rx_data_length : len_q;
      in_start = app_rx_data_valid && (pos_q == 16'd0);
      in_end   = app_rx_data_valid &&
                 ((cur_len <= 16'd1) || (pos_q == cur_len - 16'd1));
      // len<=1 is always rejected so an accepted frame never ends on its start byte.
      len_ok   = (cur_len > 16'd1) && (cur_len >= MIN_EFF) && (cur_len <= MAX_LEN);
      accept   = in_start && (state_q == IDLE) && len_ok && (app_rx_data == MAGIC);
   end

   // Next state for the tracker, the FSM, the replay path and the counters.
   always_comb begin
      state_d     = state_q;
      pos_d       = pos_q;
      len_d       = len_q;
      drop_pend_d = drop_pend_q;
      csum_d      = csum_q;
      csum_ok_d   = csum_ok_q;
      snd_len_d   = snd_len_q;
      rd_addr_d   = rd_addr_q;
      out_vld_d   = 1'b0;
      out_data_d  = out_data_q;
      out_len_d   = out_len_q;
      ok_cnt_d    = ok_cnt_q;
      wr_en       = 1'b0;
      wr_addr     = AW'(pos_q - 16'd1);
      wr_data     = app_rx_data;
      drop_trk    = 1'b0;
      drop_chk    = 1'b0;

      // Tracker runs regardless of FSM state so it stays aligned to frames.
      if (app_rx_data_valid) begin
         if (in_start) len_d = app_rx_data_length;
         if (in_end) begin
            pos_d       = 16'd0;
            drop_pend_d = 1'b0;
            drop_trk    = in_start ? !accept : drop_pend_q;
         end else begin
            pos_d = pos_q + 16'd1;
            if (in_start) drop_pend_d = !accept;
         end
      end

      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d   = RECV;
               csum_d    = app_rx_data;
               snd_len_d = app_rx_data_length - TRIM;
            end
         end
         RECV: begin
            if (app_rx_data_valid) begin
               if (in_end) begin
                  state_d = CHECK;
`ifdef UDP_FILTER_CHECKSUM_EN
                  csum_ok_d = (app_rx_data == csum_q);
`else
                  wr_en     = 1'b1;
                  csum_ok_d = 1'b1;
`endif
               end else begin
                  wr_en  = 1'b1;
                  csum_d = csum_q ^ app_rx_data;
               end
            end
         end
         CHECK: begin
            if (csum_ok_q) begin
               state_d    = SEND;
               out_vld_d  = 1'b1;
               out_data_d = mem_q[0];
               out_len_d  = snd_len_q;
               rd_addr_d  = 16'd1;
            end else begin
               state_d  = IDLE;
               drop_chk = 1'b1;
            end
         end
         SEND: begin
            if (rd_addr_q == snd_len_q) begin
               state_d  = IDLE;
               ok_cnt_d = ok_cnt_q + 16'd1;
            end else begin
               out_vld_d  = 1'b1;
               out_data_d = mem_q[rd_addr_q[AW-1:0]];
               rd_addr_d  = rd_addr_q + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      // A tracker drop and a checksum drop can land in the same cycle.
      drop_cnt_d = drop_cnt_q + {15'd0, drop_trk} + {15'd0, drop_chk};
   end

   // FSM state register.
   always_ff @(posedge udp_rx_clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Tracker, datapath, output and counter registers.
   always_ff @(posedge udp_rx_clk or posedge reset) begin
      if (reset) begin
         pos_q       <= '0;
         len_q       <= '0;
         drop_pend_q <= 1'b0;
         csum_q      <= '0;
         csum_ok_q   <= 1'b0;
         snd_len_q   <= '0;
         rd_addr_q   <= '0;
         out_vld_q   <= 1'b0;
         out_data_q  <= '0;
         out_len_q   <= '0;
         ok_cnt_q    <= '0;
         drop_cnt_q  <= '0;
      end else begin
         pos_q       <= pos_d;
         len_q       <= len_d;
         drop_pend_q <= drop_pend_d;
         csum_q      <= csum_d;
         csum_ok_q   <= csum_ok_d;
         snd_len_q   <= snd_len_d;
         rd_addr_q   <= rd_addr_d;
         out_vld_q   <= out_vld_d;
         out_data_q  <= out_data_d;
         out_len_q   <= out_len_d;
         ok_cnt_q    <= ok_cnt_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   // Payload buffer; contents are don't-care until written, so no reset.
   always_ff @(posedge udp_rx_clk) begin
      if (wr_en) mem_q[wr_addr] <= wr_data;
   end

   assign out_data_valid  = out_vld_q;
   assign out_data        = out_data_q;
   assign out_data_length = out_len_q;
   assign frame_ok_cnt    = ok_cnt_q;
   assign frame_drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_udp_rx_frame_filter.sv
// Directed bench for udp_rx_frame_filter: a vector table of frames with
// hand-written expectations, plus hand sequences for timing, overlap and reset.
module tb_udp_rx_frame_filter;

`ifdef UDP_FILTER_CHECKSUM_EN
   localparam bit CS = 1'b1;
`else
   localparam bit CS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        app_rx_data_valid;
   logic [7:0]  app_rx_data;
   logic [15:0] app_rx_data_length;
   logic        out_data_valid;
   logic [7:0]  out_data;
   logic [15:0] out_data_length;
   logic [15:0] frame_ok_cnt;
   logic [15:0] frame_drop_cnt;

   udp_rx_frame_filter dut (
      .udp_rx_clk        (clk),
      .reset             (reset),
      .app_rx_data_valid (app_rx_data_valid),
      .app_rx_data       (app_rx_data),
      .app_rx_data_length(app_rx_data_length),
      .out_data_valid    (out_data_valid),
      .out_data          (out_data),
      .out_data_length   (out_data_length),
      .frame_ok_cnt      (frame_ok_cnt),
      .frame_drop_cnt    (frame_drop_cnt)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor: records every forwarded byte with its length and cycle.
   logic [7:0]  mon_byte [0:1023];
   logic [15:0] mon_len  [0:1023];
   int          mon_cyc  [0:1023];
   int          mon_total = 0;
   int          last_in_cyc = 0;

   always @(negedge clk) begin
      if (app_rx_data_valid) last_in_cyc <= cyc;
      if (out_data_valid && mon_total < 1024) begin
         mon_byte[mon_total] <= out_data;
         mon_len[mon_total]  <= out_data_length;
         mon_cyc[mon_total]  <= cyc;
         mon_total           <= mon_total + 1;
      end
   end

   logic [7:0] fr [0:79];

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Frame: byte0=hdr, byte i = 0x11*i; with checksum the last byte is the XOR
   // of all earlier bytes (inverted when bad=1).
   task automatic build_frame(input int n, input logic [7:0] hdr, input bit bad);
      logic [7:0] x;
      for (int i = 0; i < 80; i++) fr[i] = 8'(8'h11 * i);
      fr[0] = hdr;
      if (CS && n >= 2) begin
         x = 8'h00;
         for (int i = 0; i < n - 1; i++) x = x ^ fr[i];
         fr[n-1] = x ^ (bad ? 8'hFF : 8'h00);
      end
   endtask

   task automatic send_frame(input int n, input bit gap);
      int nb;
      nb = (n <= 1) ? 1 : n;
      for (int k = 0; k < nb; k++) begin
         if (gap && k > 0) begin
            @(posedge clk); #1;
            app_rx_data_valid = 1'b0;
         end
         @(posedge clk); #1;
         app_rx_data_valid  = 1'b1;
         app_rx_data        = fr[k];
         app_rx_data_length = (k == 0) ? 16'(n) : 16'(n + 7);
      end
      @(posedge clk); #1;
      app_rx_data_valid = 1'b0;
   endtask

   typedef struct {
      int         n;
      logic [7:0] hdr;
      bit         bad;
      bit         gap;
      bit         fwd;
      int         len;
   } vec_t;

   vec_t vecs [11];

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, time %0t limit 400000", $time);
      $fatal(1);
   end

   initial begin
      int base, got, ok0, d0, ecnt;
      reset = 1'b1;
      app_rx_data_valid  = 1'b0;
      app_rx_data        = 8'h00;
      app_rx_data_length = 16'h0000;

      //           n    hdr    bad  gap  fwd  out len
      vecs[0]  = '{5,  8'hA5, 1'b0, 1'b0, 1'b1, CS ? 3 : 4};
      vecs[1]  = '{4,  8'h5A, 1'b0, 1'b0, 1'b0, 0};
      vecs[2]  = '{4,  8'hA5, 1'b1, 1'b0, !CS,  CS ? 0 : 3};
      vecs[3]  = '{2,  8'hA5, 1'b0, 1'b0, !CS,  CS ? 0 : 1};
      vecs[4]  = '{3,  8'hA5, 1'b0, 1'b0, 1'b1, CS ? 1 : 2};
      vecs[5]  = '{64, 8'hA5, 1'b0, 1'b0, 1'b1, CS ? 62 : 63};
      vecs[6]  = '{65, 8'hA5, 1'b0, 1'b0, 1'b0, 0};
      vecs[7]  = '{1,  8'hA5, 1'b0, 1'b0, 1'b0, 0};
      vecs[8]  = '{0,  8'hA5, 1'b0, 1'b0, 1'b0, 0};
      vecs[9]  = '{5,  8'hA5, 1'b0, 1'b1, 1'b1, CS ? 3 : 4};
      vecs[10] = '{5,  8'hA5, 1'b0, 1'b0, 1'b1, CS ? 3 : 4};

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("reset out_data_valid", int'(out_data_valid), 0);
      chk("reset out_data", int'(out_data), 0);
      chk("reset out_data_length", int'(out_data_length), 0);
      chk("reset frame_ok_cnt", int'(frame_ok_cnt), 0);
      chk("reset frame_drop_cnt", int'(frame_drop_cnt), 0);

      // Table-driven frames.
      for (int i = 0; i < 11; i++) begin
         base = mon_total;
         ok0  = int'(frame_ok_cnt);
         d0   = int'(frame_drop_cnt);
         build_frame(vecs[i].n, vecs[i].hdr, vecs[i].bad);
         send_frame(vecs[i].n, vecs[i].gap);
         repeat (vecs[i].n + 12) @(posedge clk);
         @(negedge clk);
         ecnt = vecs[i].fwd ? vecs[i].len : 0;
         got  = mon_total - base;
         chk($sformatf("v%0d out count", i), got, ecnt);
         for (int j = 0; j < got && j < ecnt; j++) begin
            chk($sformatf("v%0d byte %0d", i, j), int'(mon_byte[base+j]), int'(fr[j+1]));
            chk($sformatf("v%0d length %0d", i, j), int'(mon_len[base+j]), vecs[i].len);
            chk($sformatf("v%0d contiguous %0d", i, j), mon_cyc[base+j] - mon_cyc[base], j);
         end
         if (vecs[i].fwd && got > 0) begin
            chk($sformatf("v%0d latency", i), mon_cyc[base] - last_in_cyc, 2);
            chk($sformatf("v%0d valid low after", i), int'(out_data_valid), 0);
            chk($sformatf("v%0d data held", i), int'(out_data), int'(fr[vecs[i].len]));
         end
         chk($sformatf("v%0d ok delta", i), int'(16'(frame_ok_cnt - 16'(ok0))), int'(vecs[i].fwd));
         chk($sformatf("v%0d drop delta", i), int'(16'(frame_drop_cnt - 16'(d0))), int'(!vecs[i].fwd));
      end

      // Bad magic: drop counted on the cycle the end byte is taken.
      d0 = int'(frame_drop_cnt);
      build_frame(4, 8'h5A, 1'b0);
      send_frame(4, 1'b0);
      chk("badmagic drop at end byte", int'(frame_drop_cnt), d0 + 1);

      // Bad checksum: no drop yet at the end byte, counted after CHECK.
      repeat (4) @(posedge clk);
      #1;
      d0 = int'(frame_drop_cnt);
      build_frame(4, 8'hA5, 1'b1);
      send_frame(4, 1'b0);
      chk("badcsum drop before check", int'(frame_drop_cnt), d0);
      @(posedge clk); #1;
      chk("badcsum drop after check", int'(frame_drop_cnt), d0 + int'(CS));
      repeat (10) @(posedge clk);

      // Busy overlap: second frame starts while the first is in SEND.
      base = mon_total;
      ok0  = int'(frame_ok_cnt);
      d0   = int'(frame_drop_cnt);
      build_frame(5, 8'hA5, 1'b0);
      send_frame(5, 1'b0);
      send_frame(5, 1'b0);
      repeat (15) @(posedge clk);
      @(negedge clk);
      ecnt = CS ? 3 : 4;
      chk("overlap out count", mon_total - base, ecnt);
      for (int j = 0; j < ecnt && j < mon_total - base; j++)
         chk($sformatf("overlap byte %0d", j), int'(mon_byte[base+j]), int'(fr[j+1]));
      chk("overlap ok delta", int'(16'(frame_ok_cnt - 16'(ok0))), 1);
      chk("overlap drop delta", int'(16'(frame_drop_cnt - 16'(d0))), 1);

      // Reset in the middle of RECV, then a good frame.
      build_frame(5, 8'hA5, 1'b0);
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         app_rx_data_valid  = 1'b1;
         app_rx_data        = fr[k];
         app_rx_data_length = 16'd5;
      end
      @(posedge clk); #1;
      app_rx_data_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      chk("midreset ok cnt", int'(frame_ok_cnt), 0);
      chk("midreset drop cnt", int'(frame_drop_cnt), 0);
      chk("midreset out length", int'(out_data_length), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      base = mon_total;
      send_frame(5, 1'b0);
      repeat (15) @(posedge clk);
      @(negedge clk);
      chk("postreset out count", mon_total - base, ecnt);
      for (int j = 0; j < ecnt && j < mon_total - base; j++)
         chk($sformatf("postreset byte %0d", j), int'(mon_byte[base+j]), int'(fr[j+1]));
      chk("postreset ok cnt", int'(frame_ok_cnt), 1);
      chk("postreset drop cnt", int'(frame_drop_cnt), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
